lift_car_fsm: RTL



---
 rtl/lift_pkg.sv | 19 +
 rtl/tick_sync.sv | 32 +++
 rtl/lift_car_fsm.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lift_pkg.sv
// Shared types and defaults for the lift car controller and its helpers.
package lift_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR      = 2'd3
    } lift_state_e;

    localparam int FLOORS_DEF       = 8;
    localparam int TRAVEL_TICKS_DEF = 3;
    localparam int DOOR_TICKS_DEF   = 2;

    function automatic int floor_width(input int floors);
        return (floors > 1) ? $clog2(floors) : 1;
    endfunction

endpackage

// File: rtl/tick_sync.sv
// Brings a divider slow clock into the fast domain as data and emits a
// single-cycle tick per rising edge, three fast cycles after the edge.
module tick_sync (
    input  logic clk_100MHz,
    input  logic rst,
    input  logic clk_s,
    output logic tick
);

    logic sync1_r;
    logic sync2_r;
    logic sync3_r;
    logic tick_r;

    // Two-flop synchronizer, edge-history flop and registered rising-edge pulse
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            sync3_r <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            sync1_r <= clk_s;
            sync2_r <= sync1_r;
            sync3_r <= sync2_r;
            tick_r  <= sync2_r & ~sync3_r;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/lift_car_fsm.sv
// Collective, direction-preserving lift car controller: latches floor calls,
// moves the car one floor per TRAVEL_TICKS ticks and dwells DOOR_TICKS at stops.
module lift_car_fsm
    import lift_pkg::*;
#(
    parameter int FLOORS       = FLOORS_DEF,
    parameter int TRAVEL_TICKS = TRAVEL_TICKS_DEF,
    parameter int DOOR_TICKS   = DOOR_TICKS_DEF
) (
    input  logic                           clk_100MHz,
    input  logic                           rst,
    input  logic                           clk_s,
    input  logic [FLOORS-1:0]              req,
    output logic [floor_width(FLOORS)-1:0] floor,
    output logic                           moving,
    output logic                           dir_up,
    output logic                           dir_down,
    output logic                           door_open,
    output logic [FLOORS-1:0]              pending
);

    localparam int FLOOR_W = floor_width(FLOORS);
    localparam int CNT_MAX = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]   TRAVEL_LAST = CNT_W'(TRAVEL_TICKS - 1);
    localparam logic [CNT_W-1:0]   DOOR_LAST   = CNT_W'(DOOR_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP   = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_ONE   = FLOOR_W'(1);
    localparam logic [FLOOR_W-1:0] FLOOR_BOT   = {FLOOR_W{1'b0}};

    lift_state_e         state_r;
    logic [FLOOR_W-1:0]  floor_r;
    logic [CNT_W-1:0]    cnt_r;
    logic [FLOORS-1:0]   pending_r;
    logic                moving_r;
    logic                dir_up_r;
    logic                dir_down_r;
    logic                door_open_r;

    logic                tick_s;
    logic [FLOOR_W-1:0]  nf_s;
    logic                at_limit_s;
    logic [FLOORS-1:0]   floor_oh_s;
    logic [FLOORS-1:0]   nf_oh_s;
    logic                above_s;
    logic                below_s;
    logic                here_s;
    logic                req_here_s;
    logic                nf_here_s;
    logic                nf_above_s;
    logic                nf_below_s;
    logic                ahead_s;
    logic                arrive_s;
    logic                door_done_s;
    logic                door_up_s;
    logic                door_down_s;
    logic [FLOORS-1:0]   clr_s;
    logic [FLOORS-1:0]   pend_next_s;

    tick_sync u_sync (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .clk_s      (clk_s),
        .tick       (tick_s)
    );

    // Floor the car would reach on the next arrival, and the end-of-shaft guard
    always_comb begin
        nf_s       = floor_r;
        at_limit_s = 1'b0;
        case (state_r)
            MOVE_UP: begin
                at_limit_s = (floor_r == FLOOR_TOP);
                nf_s       = at_limit_s ? floor_r : floor_r + FLOOR_ONE;
            end
            MOVE_DOWN: begin
                at_limit_s = (floor_r == FLOOR_BOT);
                nf_s       = at_limit_s ? floor_r : floor_r - FLOOR_ONE;
            end
            default: begin
                nf_s       = floor_r;
                at_limit_s = 1'b0;
            end
        endcase
    end

    // Call reductions relative to the current floor and to the arrival floor
    always_comb begin
        floor_oh_s = '0;
        nf_oh_s    = '0;
        above_s    = 1'b0;
        below_s    = 1'b0;
        here_s     = 1'b0;
        req_here_s = 1'b0;
        nf_here_s  = 1'b0;
        nf_above_s = 1'b0;
        nf_below_s = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            floor_oh_s[i] = (i == int'(floor_r));
            nf_oh_s[i]    = (i == int'(nf_s));
            above_s       = above_s    | (pending_r[i] & (i >  int'(floor_r)));
            below_s       = below_s    | (pending_r[i] & (i <  int'(floor_r)));
            here_s        = here_s     | (pending_r[i] & (i == int'(floor_r)));
            req_here_s    = req_here_s | (req[i]       & (i == int'(floor_r)));
            nf_here_s     = nf_here_s  | (pending_r[i] & (i == int'(nf_s)));
            nf_above_s    = nf_above_s | (pending_r[i] & (i >  int'(nf_s)));
            nf_below_s    = nf_below_s | (pending_r[i] & (i <  int'(nf_s)));
        end
    end

    // Arrival/dwell strobes; a car heading down keeps preferring calls below
    always_comb begin
        arrive_s    = tick_s & (cnt_r == TRAVEL_LAST);
        door_done_s = tick_s & (cnt_r == DOOR_LAST);
        ahead_s     = (state_r == MOVE_UP) ? nf_above_s : nf_below_s;
        door_up_s   = dir_down_r ? (above_s & ~below_s) : above_s;
        door_down_s = dir_down_r ? below_s : (below_s & ~above_s);
    end

    // Call being served this cycle; it wins over a simultaneous request
    always_comb begin
        clr_s = '0;
        case (state_r)
            IDLE:      clr_s = here_s ? floor_oh_s : '0;
            MOVE_UP,
            MOVE_DOWN: clr_s = (!at_limit_s && arrive_s && nf_here_s) ? nf_oh_s : '0;
            DOOR:      clr_s = req_here_s ? floor_oh_s : '0;
            default:   clr_s = '0;
        endcase
        pend_next_s = (pending_r | req) & ~clr_s;
    end

    // Car state machine, tick counter, call latch and registered outputs
    always_ff @(posedge clk_100MHz) begin
        if (rst) begin
            state_r     <= IDLE;
            floor_r     <= '0;
            cnt_r       <= '0;
            pending_r   <= '0;
            moving_r    <= 1'b0;
            dir_up_r    <= 1'b0;
            dir_down_r  <= 1'b0;
            door_open_r <= 1'b0;
        end else begin
            pending_r <= pend_next_s;
            case (state_r)
                IDLE: begin
                    cnt_r <= '0;
                    if (here_s) begin
                        state_r     <= DOOR;
                        moving_r    <= 1'b0;
                        door_open_r <= 1'b1;
                    end else if (above_s) begin
                        state_r     <= MOVE_UP;
                        moving_r    <= 1'b1;
                        door_open_r <= 1'b0;
                        dir_up_r    <= 1'b1;
                        dir_down_r  <= 1'b0;
                    end else if (below_s) begin
                        state_r     <= MOVE_DOWN;
                        moving_r    <= 1'b1;
                        door_open_r <= 1'b0;
                        dir_up_r    <= 1'b0;
                        dir_down_r  <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        moving_r    <= 1'b0;
                        door_open_r <= 1'b0;
                        dir_up_r    <= 1'b0;
                        dir_down_r  <= 1'b0;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (at_limit_s) begin
                        state_r  <= IDLE;
                        moving_r <= 1'b0;
                        cnt_r    <= '0;
                    end else if (arrive_s) begin
                        floor_r <= nf_s;
                        cnt_r   <= '0;
                        if (nf_here_s) begin
                            state_r     <= DOOR;
                            moving_r    <= 1'b0;
                            door_open_r <= 1'b1;
                        end else if (ahead_s) begin
                            state_r <= state_r;
                        end else begin
                            state_r  <= IDLE;
                            moving_r <= 1'b0;
                            if (pend_next_s == '0) begin
                                dir_up_r   <= 1'b0;
                                dir_down_r <= 1'b0;
                            end else begin
                                dir_up_r   <= dir_up_r;
                                dir_down_r <= dir_down_r;
                            end
                        end
                    end else if (tick_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                DOOR: begin
                    if (req_here_s) begin
                        cnt_r <= '0;
                    end else if (door_done_s) begin
                        cnt_r       <= '0;
                        door_open_r <= 1'b0;
                        if (door_up_s) begin
                            state_r    <= MOVE_UP;
                            moving_r   <= 1'b1;
                            dir_up_r   <= 1'b1;
                            dir_down_r <= 1'b0;
                        end else if (door_down_s) begin
                            state_r    <= MOVE_DOWN;
                            moving_r   <= 1'b1;
                            dir_up_r   <= 1'b0;
                            dir_down_r <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            if (pend_next_s == '0) begin
                                dir_up_r   <= 1'b0;
                                dir_down_r <= 1'b0;
                            end else begin
                                dir_up_r   <= dir_up_r;
                                dir_down_r <= dir_down_r;
                            end
                        end
                    end else if (tick_s) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    moving_r    <= 1'b0;
                    door_open_r <= 1'b0;
                    cnt_r       <= '0;
                end
            endcase
        end
    end

    assign floor     = floor_r;
    assign moving    = moving_r;
    assign dir_up    = dir_up_r;
    assign dir_down  = dir_down_r;
    assign door_open = door_open_r;
    assign pending   = pending_r;

endmodule
